// File: rtl/block_lock_fsm.sv
// block_lock_fsm: 64b/66b sync-header block lock controller with gearbox bit-slip
module block_lock_fsm #(
  parameter int HEAD_W       = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2,
  parameter int SLIP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  signal_ok_i,
  input  logic                  valid_i,
  input  logic [HEAD_W-1:0]     head_i,
  output logic                  slip_v_o,
  output logic                  block_lock_o,
  output logic [SLIP_CNT_W-1:0] slip_cnt_o
);
  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVLD_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SH_CNT_MAX - 1);
  localparam logic [IW-1:0] I_LAST = IW'(SH_INVLD_MAX - 1);
  localparam logic [WW-1:0] W_LAST = WW'(SLIP_WAIT - 1);
  typedef enum logic [1:0] {S_INIT, S_TEST, S_SLIP_WAIT, S_LOCKED} state_t;
  state_t state;
  logic [CW-1:0] sh_cnt;
  logic [IW-1:0] sh_invld_cnt;
  logic [WW-1:0] wait_cnt;
  logic sh_valid;
  logic [SLIP_CNT_W-1:0] slip_next;
  always_comb begin
    sh_valid  = head_i[1] ^ head_i[0];
    slip_next = &slip_cnt_o ? slip_cnt_o : slip_cnt_o + 1'b1;
  end
  // slip_v_o defaults low each cycle, so a slip is always a single-cycle pulse
  always_ff @(posedge clk) begin
    if (nreset || !signal_ok_i) begin
      state        <= S_INIT;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      slip_v_o     <= 1'b0;
      block_lock_o <= 1'b0;
      slip_cnt_o   <= '0;
    end else begin
      slip_v_o <= 1'b0;
      case (state)
        S_INIT: state <= S_TEST;
        S_TEST: if (valid_i) begin
          if (!sh_valid) begin
            slip_v_o   <= 1'b1;
            sh_cnt     <= '0;
            slip_cnt_o <= slip_next;
            wait_cnt   <= '0;
            state      <= S_SLIP_WAIT;
          end else if (sh_cnt == C_LAST) begin
            block_lock_o <= 1'b1;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            slip_cnt_o   <= '0;
            state        <= S_LOCKED;
          end else
            sh_cnt <= sh_cnt + 1'b1;
        end
        S_SLIP_WAIT: if (wait_cnt == W_LAST) begin
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
          wait_cnt     <= '0;
          state        <= S_TEST;
        end else
          wait_cnt <= wait_cnt + 1'b1;
        S_LOCKED: if (valid_i) begin
          if (!sh_valid && sh_invld_cnt == I_LAST) begin
            block_lock_o <= 1'b0;
            slip_v_o     <= 1'b1;
            slip_cnt_o   <= SLIP_CNT_W'(1);
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
            state        <= S_SLIP_WAIT;
          end else if (sh_cnt == C_LAST) begin
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
          end else begin
            sh_cnt       <= sh_cnt + 1'b1;
            sh_invld_cnt <= sh_invld_cnt + IW'(!sh_valid);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_block_lock_fsm.sv
// tb_block_lock_fsm: per-scenario tasks with an expected-output scoreboard queue
module tb_block_lock_fsm;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic signal_ok_i = 1'b0;
  logic valid_i = 1'b0;
  logic [1:0] head_i = 2'b00;
  logic slip_v_o, block_lock_o;
  logic [7:0] slip_cnt_o;
  int errors = 0;
  int checks = 0;

  typedef struct packed {logic s; logic l; logic [7:0] c;} exp_t;
  exp_t q[$];
  exp_t e;

  block_lock_fsm dut (
    .clk(clk), .nreset(nreset), .signal_ok_i(signal_ok_i), .valid_i(valid_i),
    .head_i(head_i), .slip_v_o(slip_v_o), .block_lock_o(block_lock_o), .slip_cnt_o(slip_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic ok, input logic v, input logic [1:0] h);
    nreset = r; signal_ok_i = ok; valid_i = v; head_i = h;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      q.push_back({1'b0, 1'b0, 8'd0});
      drive(1'b1, 1'b1, 1'($urandom), 2'($urandom));
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
    q.push_back({1'b0, 1'b0, 8'd0});
    drive(1'b0, 1'b1, 1'b1, 2'b01);
    e = q.pop_front(); checks++;
    if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
      errors++;
      $display("FAIL reset_release: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
    end
  endtask

  task automatic test_clean_lock;
    for (int i = 0; i < 64; i++) begin
      q.push_back({1'b0, i == 63, 8'd0});
      drive(1'b0, 1'b1, 1'b1, i[0] ? 2'b10 : 2'b01);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL clean_lock[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_signal_loss;
    q.push_back({1'b0, 1'b0, 8'd0});
    q.push_back({1'b0, 1'b0, 8'd0});
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, i == 1, 1'b1, 2'b11);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL signal_loss[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_hunt_slip;
    logic [1:0] h;
    logic v;
    for (int i = 0; i < 76; i++) begin
      if (i < 9) begin h = 2'b10; q.push_back({1'b0, 1'b0, 8'd0}); end
      else if (i == 9) begin h = 2'b11; q.push_back({1'b1, 1'b0, 8'd1}); end
      else if (i < 12) begin h = 2'b00; q.push_back({1'b0, 1'b0, 8'd1}); end
      else begin h = 2'b01; q.push_back(i == 75 ? {1'b0, 1'b1, 8'd0} : {1'b0, 1'b0, 8'd1}); end
      v = 1'b1;
      drive(1'b0, 1'b1, v, h);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL hunt_slip[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_err_threshold;
    logic bad;
    for (int i = 0; i < 64 + 32 + 2; i++) begin
      if (i < 64) begin
        bad = (i % 4 == 0) && i < 60;
        q.push_back({1'b0, 1'b1, 8'd0});
      end else if (i < 96) begin
        bad = (i - 64) % 2 == 1;
        q.push_back(i == 95 ? {1'b1, 1'b0, 8'd1} : {1'b0, 1'b1, 8'd0});
      end else begin
        bad = 1'b1;
        q.push_back({1'b0, 1'b0, 8'd1});
      end
      drive(1'b0, 1'b1, 1'b1, bad ? (i[1] ? 2'b11 : 2'b00) : 2'b10);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL err_threshold[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 128; i++) begin
      q.push_back(i >= 126 ? {1'b0, 1'b1, 8'd0} : {1'b0, 1'b0, 8'd1});
      drive(1'b0, 1'b1, ~i[0], i[0] ? 2'b11 : 2'b01);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL gaps[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_saturation;
    int n;
    for (int i = 0; i < 2 + 300 * 3; i++) begin
      n = (i - 2) / 3 + 1;
      if (n > 255) n = 255;
      if (i < 2) q.push_back({1'b0, 1'b0, 8'd0});
      else q.push_back({(i - 2) % 3 == 0, 1'b0, 8'(n)});
      drive(1'b0, i != 0, 1'b1, 2'b11);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL saturation[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic r, ok;
    for (int i = 0; i < 7; i++) begin
      r = i == 1;
      ok = i != 5;
      case (i)
        0: q.push_back({1'b1, 1'b0, 8'd255});
        3: q.push_back({1'b1, 1'b0, 8'd1});
        4: q.push_back({1'b0, 1'b0, 8'd1});
        default: q.push_back({1'b0, 1'b0, 8'd0});
      endcase
      drive(r, ok, 1'b1, 2'b00);
      e = q.pop_front(); checks++;
      if ({slip_v_o, block_lock_o, slip_cnt_o} !== e) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got slip=%b lock=%b cnt=%0d want slip=%b lock=%b cnt=%0d", i, slip_v_o, block_lock_o, slip_cnt_o, e.s, e.l, e.c);
      end
    end
  endtask

  initial begin
    test_reset;
    test_clean_lock;
    test_signal_loss;
    test_hunt_slip;
    test_err_threshold;
    test_gaps;
    test_saturation;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
